// File: rtl/zmc_pkg.sv
// rtl/zmc_pkg.sv - shared constants and helpers for the zmc_banker bank mapper
package zmc_pkg;

    localparam int MA_LO_W = 3;

    // Upper-address decode patterns, most significant bits of SDA_U
    localparam logic [1:0] DEC_W3 = 2'b10;
    localparam logic [2:0] DEC_W2 = 3'b110;
    localparam logic [3:0] DEC_W1 = 4'b1110;
    localparam logic [3:0] DEC_W0 = 4'b1111;

    function automatic int win_base(input int w);
        return 65536 - (1 << (12 + w));
    endfunction

    // Identity map: window w starts on bank 2^(5-w)-2
    function automatic int bank_reset(input int w, input int bank_w);
        int v;
        v = (1 << (5 - w)) - 2;
        if (bank_w >= 31) begin
            return v;
        end
        return v & ((1 << bank_w) - 1);
    endfunction

    function automatic bit num_win_ok(input int n);
        return (n >= 1) && (n <= 4);
    endfunction

    function automatic int clamp_num_win(input int n);
        if (num_win_ok(n)) begin
            return n;
        end
        return (n < 1) ? 1 : 4;
    endfunction

endpackage

// File: rtl/zmc_strobe_sync.sv
// rtl/zmc_strobe_sync.sv - SDRD0 synchroniser, edge detect and aligned write-data shadow
module zmc_strobe_sync (
    input  logic       clk,
    input  logic       rst,
    input  logic       strobe,
    input  logic [1:0] idx_in,
    input  logic [7:0] val_in,
    output logic       commit,
    output logic [1:0] idx,
    output logic [7:0] val
);

    logic [2:0] sync_q, sync_d;
    logic [9:0] shad1_q, shad1_d;
    logic [9:0] shad2_q, shad2_d;
    logic [1:0] warm_q, warm_d;
    logic       armed_q, armed_d;

    // A strobe already high when reset releases must not commit: the edge
    // detector arms only once a low level has come through the synchroniser.
    always_comb begin
        sync_d  = {sync_q[1:0], strobe};
        shad1_d = {idx_in, val_in};
        shad2_d = shad1_q;
        warm_d  = {warm_q[0], 1'b1};
        armed_d = armed_q | (warm_q[1] & ~sync_q[1]);
        commit  = sync_q[1] & ~sync_q[2] & armed_q;
        idx     = shad2_q[9:8];
        val     = shad2_q[7:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            shad1_q <= '0;
            shad2_q <= '0;
            warm_q  <= '0;
            armed_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            shad1_q <= shad1_d;
            shad2_q <= shad2_d;
            warm_q  <= warm_d;
            armed_q <= armed_d;
        end
    end

endmodule

// File: rtl/zmc_banker.sv
// rtl/zmc_banker.sv - Z80 upper-window bank mapper; ZMC_READBACK_EN adds the RB_DATA readback port
module zmc_banker
    import zmc_pkg::*;
#(
    parameter int NUM_WIN = 4,
    parameter int BANK_W  = 8
) (
    input  logic                        CLK_24M,
    input  logic                        RESET,
    input  logic                        SDRD0,
    input  logic [1:0]                  SDA_L,
    input  logic [7:0]                  SDA_U,
`ifdef ZMC_READBACK_EN
    output logic [BANK_W-1:0]           RB_DATA,
`endif
    output logic [BANK_W+MA_LO_W-1:0]   MA
);

    localparam int MA_W = BANK_W + MA_LO_W;
    localparam int NW   = clamp_num_win(NUM_WIN);

    logic [7:0]        sda_u_q, sda_u_d;
    logic [MA_W-1:0]   ma_q, ma_d;
    logic [BANK_W-1:0] bank_q [4];
    logic [BANK_W-1:0] bank_d [4];
    logic              commit;
    logic [1:0]        commit_idx;
    logic [7:0]        commit_val;
    logic [1:0]        win;
    logic              win_hit;

    zmc_strobe_sync u_sync (
        .clk    (CLK_24M),
        .rst    (RESET),
        .strobe (SDRD0),
        .idx_in (SDA_L),
        .val_in (SDA_U),
        .commit (commit),
        .idx    (commit_idx),
        .val    (commit_val)
    );

    always_comb begin
        sda_u_d = SDA_U;
        win     = 2'd0;
        win_hit = 1'b0;
        if (sda_u_q[7:6] == DEC_W3) begin
            win     = 2'd3;
            win_hit = 1'b1;
        end else if (sda_u_q[7:5] == DEC_W2) begin
            win     = 2'd2;
            win_hit = 1'b1;
        end else if (sda_u_q[7:4] == DEC_W1) begin
            win     = 2'd1;
            win_hit = 1'b1;
        end else if (sda_u_q[7:4] == DEC_W0) begin
            win     = 2'd0;
            win_hit = 1'b1;
        end
        if (int'(win) >= NW) begin
            win_hit = 1'b0;
        end

        // Pass-through keeps A15..A11 untouched
        ma_d = MA_W'(sda_u_q[7:3]);
        if (win_hit) begin
            case (win)
                2'd0:    ma_d = MA_W'(bank_q[0]);
                2'd1:    ma_d = MA_W'({bank_q[1], sda_u_q[3]});
                2'd2:    ma_d = MA_W'({bank_q[2], sda_u_q[4:3]});
                default: ma_d = MA_W'({bank_q[3], sda_u_q[5:3]});
            endcase
        end
    end

    always_comb begin
        for (int w = 0; w < 4; w++) begin
            bank_d[w] = bank_q[w];
        end
        if (commit && (int'(commit_idx) < NW)) begin
            bank_d[commit_idx] = BANK_W'(commit_val);
        end
    end

    always_ff @(posedge CLK_24M or posedge RESET) begin
        if (RESET) begin
            sda_u_q <= '0;
            ma_q    <= '0;
            for (int w = 0; w < 4; w++) begin
                bank_q[w] <= BANK_W'(bank_reset(w, BANK_W));
            end
        end else begin
            sda_u_q <= sda_u_d;
            ma_q    <= ma_d;
            for (int w = 0; w < 4; w++) begin
                bank_q[w] <= bank_d[w];
            end
        end
    end

    assign MA = ma_q;

`ifdef ZMC_READBACK_EN
    logic [BANK_W-1:0] rb_q, rb_d;

    // Reads the pre-commit bank, so a same-edge write shows up one clock later
    always_comb begin
        rb_d = '0;
        if (int'(SDA_L) < NW) begin
            rb_d = bank_q[SDA_L];
        end
    end

    always_ff @(posedge CLK_24M or posedge RESET) begin
        if (RESET) begin
            rb_q <= '0;
        end else begin
            rb_q <= rb_d;
        end
    end

    assign RB_DATA = rb_q;
`endif

endmodule

// File: tb/tb_zmc_banker.sv
// tb/tb_zmc_banker.sv - self-checking bench for zmc_banker at NUM_WIN 4, 2 and 3
module tb_zmc_banker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sdrd0 = 1'b0;
    logic [1:0]  sda_l = 2'd0;
    logic [7:0]  sda_u = 8'd0;
    logic [10:0] ma [3];
`ifdef ZMC_READBACK_EN
    logic [7:0]  rb [3];
`endif

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    zmc_banker #(.NUM_WIN(4), .BANK_W(8)) u_nw4 (
        .CLK_24M (clk),
        .RESET   (rst),
        .SDRD0   (sdrd0),
        .SDA_L   (sda_l),
        .SDA_U   (sda_u),
`ifdef ZMC_READBACK_EN
        .RB_DATA (rb[0]),
`endif
        .MA      (ma[0])
    );

    zmc_banker #(.NUM_WIN(2), .BANK_W(8)) u_nw2 (
        .CLK_24M (clk),
        .RESET   (rst),
        .SDRD0   (sdrd0),
        .SDA_L   (sda_l),
        .SDA_U   (sda_u),
`ifdef ZMC_READBACK_EN
        .RB_DATA (rb[1]),
`endif
        .MA      (ma[1])
    );

    zmc_banker #(.NUM_WIN(3), .BANK_W(8)) u_nw3 (
        .CLK_24M (clk),
        .RESET   (rst),
        .SDRD0   (sdrd0),
        .SDA_L   (sda_l),
        .SDA_U   (sda_u),
`ifdef ZMC_READBACK_EN
        .RB_DATA (rb[2]),
`endif
        .MA      (ma[2])
    );

    // Model state: per-instance banks, plus strobe/data samples of the last
    // three clock edges since reset (index 0 = most recent edge).
    int m_nw [3] = '{4, 2, 3};
    int m_bank [3][4];
    int exp_ma [3];
    int exp_rb [3];
    int nsmp = 0;
    int lvl_h [3];
    int l_h [3];
    int u_h [3];
    int n_commits = 0;

    function automatic int map_ma(input int sda, input int i);
        int addr;
        int base;
        int size;
        addr = sda << 8;
        for (int w = 0; w < 4; w++) begin
            base = 65536 - (1 << (12 + w));
            size = 1 << (11 + w);
            if (addr >= base && (addr < base + size || w == 0)) begin
                if (w < m_nw[i]) begin
                    return ((m_bank[i][w] << w) | (((addr - base) >> 11) & ((1 << w) - 1))) & 'h7FF;
                end
            end
        end
        return addr >> 11;
    endfunction

    always begin
        @(posedge clk or posedge rst);
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                m_bank[i] = '{'h1E, 'h0E, 'h06, 'h02};
                exp_ma[i] = 0;
                exp_rb[i] = 0;
                lvl_h[i]  = 0;
                l_h[i]    = 0;
                u_h[i]    = 0;
            end
            nsmp = 0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                exp_ma[i] = map_ma((nsmp >= 1) ? u_h[0] : 0, i);
                exp_rb[i] = (int'(sda_l) < m_nw[i]) ? m_bank[i][sda_l] : 0;
            end
            // Commit lands on the third edge after a sampled low-to-high step
            if (nsmp >= 3 && lvl_h[2] == 0 && lvl_h[1] == 1) begin
                n_commits++;
                for (int i = 0; i < 3; i++) begin
                    if (l_h[1] < m_nw[i]) begin
                        m_bank[i][l_h[1]] = u_h[1];
                    end
                end
            end
            for (int j = 2; j > 0; j--) begin
                lvl_h[j] = lvl_h[j-1];
                l_h[j]   = l_h[j-1];
                u_h[j]   = u_h[j-1];
            end
            lvl_h[0] = int'(sdrd0);
            l_h[0]   = int'(sda_l);
            u_h[0]   = int'(sda_u);
            if (nsmp < 3) begin
                nsmp++;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always begin
        @(negedge clk);
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("ma_inst%0d", i), 32'(ma[i]), 32'(exp_ma[i]));
`ifdef ZMC_READBACK_EN
                check($sformatf("rb_inst%0d", i), 32'(rb[i]), 32'(exp_rb[i]));
`endif
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_write(input logic [1:0] idx, input logic [7:0] val, input int hi);
        sda_l = idx;
        sda_u = val;
        sdrd0 = 1'b1;
        step(hi);
        sdrd0 = 1'b0;
    endtask

    int c0;

    initial begin
        step(3);
        check("ma_reset", 32'(ma[0]), 32'h000);
        chk_en = 1'b1;
        rst = 1'b0;
        step(1);

        sda_u = 8'h9A; step(2);
        check("rd_9a", 32'(ma[0]), 32'h013);
        sda_u = 8'hF3; step(2);
        check("rd_f3", 32'(ma[0]), 32'h01E);
        sda_u = 8'h45; step(2);
        check("rd_45_pass", 32'(ma[0]), 32'h008);

        // Window 3 write; SDA_U moves to a window-3 read once the data is captured
        sda_l = 2'd3; sda_u = 8'h5C; sdrd0 = 1'b1;
        step(1);
        sda_u = 8'h80;
        step(2);
        check("w3_pre_commit", 32'(ma[0]), 32'h010);
        step(1);
        check("w3_post_commit", 32'(ma[0]), 32'h2E0);
        check("w3_nw2_pass", 32'(ma[1]), 32'h010);
        sdrd0 = 1'b0;
        step(3);

        pulse_write(2'd2, 8'hFF, 3);
        sda_u = 8'hC0;
        step(3);
        check("w2_ignored_nw2", 32'(ma[1]), 32'h018);
        check("w2_taken_nw4", 32'(ma[0]), 32'h3FC);

        c0 = n_commits;
        sda_l = 2'd1; sda_u = 8'h11; sdrd0 = 1'b1;
        step(5);
        sda_u = 8'h22;
        step(15);
        sdrd0 = 1'b0;
        step(3);
        check("held_one_commit", 32'(n_commits - c0), 32'd1);
        sda_u = 8'hE8; step(2);
        check("held_val_nw4", 32'(ma[0]), 32'h023);
        check("held_val_nw2", 32'(ma[1]), 32'h023);

        c0 = n_commits;
        sda_l = 2'd0; sda_u = 8'h77; sdrd0 = 1'b1;
        step(1);
        rst = 1'b1;
        #1;
        check("ma_async_reset", 32'(ma[0]), 32'h000);
        step(2);
        rst = 1'b0;
        step(6);
        sda_u = 8'hF0; step(2);
        check("rst_bank0", 32'(ma[0]), 32'h01E);
        sda_u = 8'hE0; step(2);
        check("rst_bank1", 32'(ma[0]), 32'h01C);
        sda_u = 8'hC0; step(2);
        check("rst_bank2", 32'(ma[0]), 32'h018);
        sda_u = 8'h80; step(2);
        check("rst_bank3", 32'(ma[0]), 32'h010);
        sdrd0 = 1'b0;
        step(4);
        check("rst_no_commit", 32'(n_commits - c0), 32'd0);

        pulse_write(2'd1, 8'hA5, 3);
        sda_u = 8'h00;
        step(3);
        sda_l = 2'd1;
        step(1);
`ifdef ZMC_READBACK_EN
        check("rb_idx1", 32'(rb[0]), 32'h0A5);
`endif
        sda_l = 2'd3;
        step(1);
`ifdef ZMC_READBACK_EN
        check("rb_idx3_nw3", 32'(rb[2]), 32'h000);
        check("rb_idx3_nw4", 32'(rb[0]), 32'h002);
`endif
        sda_u = 8'hE0; step(2);
        check("a5_bank1", 32'(ma[0]), 32'h14A);
        step(2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
